// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared width defaults and busy-vector sizing for the scoreboard RF.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_DEF = 32;
    localparam int ADDR_DEF = 5;

    function automatic int busy_width(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int BUSY_W = busy_width(ADDR_DEF);

endpackage

`default_nettype wire

// File: rtl/regfile_sb_busy.sv
// ============================================================================
// Module : regfile_sb_busy
// Brief  : Per-register busy bits (set on issue, cleared on write) + popcount.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_sb_busy
    import regfile_pkg::*;
#(
    parameter int ADDR     = ADDR_DEF,
    parameter int WRITE    = 2,
    parameter int ISSUE    = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [WRITE-1:0][ADDR-1:0]   waddr,
    input  logic [WRITE-1:0]             we_,
    input  logic [ISSUE-1:0][ADDR-1:0]   set_addr,
    input  logic [ISSUE-1:0]             set_,
    input  logic                         flush_,
    output logic [busy_width(ADDR)-1:0]  busy,
    output logic [ADDR:0]                busy_cnt
);

    localparam int DEPTH = busy_width(ADDR);
    localparam int CNT_W = ADDR + 1;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;

    // Sets are applied after clears so a same-cycle set wins; flush overrides both.
    always_comb begin
        w_next = r_busy;
        for (int j = 0; j < WRITE; j++) begin
            if (!we_[j]) begin
                w_next[waddr[j]] = 1'b0;
            end
        end
        for (int k = 0; k < ISSUE; k++) begin
            if (!set_[k]) begin
                w_next[set_addr[k]] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            w_next[0] = 1'b0;
        end
        if (!flush_) begin
            w_next = '0;
        end
        w_cnt = '0;
        for (int a = 0; a < DEPTH; a++) begin
            w_cnt = w_cnt + CNT_W'(w_next[a]);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_next;
            r_cnt  <= w_cnt;
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module : regfile_sb
// Brief  : Multi-port register file with write bypass and busy scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA     = DATA_DEF,
    parameter int ADDR     = ADDR_DEF,
    parameter int READ     = 4,
    parameter int WRITE    = 2,
    parameter int ISSUE    = 2,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [READ-1:0][ADDR-1:0]    raddr,
    output logic [READ-1:0][DATA-1:0]    rdata,
    output logic [READ-1:0]              rbusy,
    input  logic [WRITE-1:0][ADDR-1:0]   waddr,
    input  logic [WRITE-1:0]             we_,
    input  logic [WRITE-1:0][DATA-1:0]   wdata,
    input  logic [ISSUE-1:0][ADDR-1:0]   set_addr,
    input  logic [ISSUE-1:0]             set_,
    input  logic                         flush_,
    output logic [ADDR:0]                busy_cnt
);

    localparam int DEPTH = busy_width(ADDR);

    logic [DATA-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0] w_busy;

    regfile_sb_busy #(
        .ADDR     (ADDR),
        .WRITE    (WRITE),
        .ISSUE    (ISSUE),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .reset_   (reset_),
        .waddr    (waddr),
        .we_      (we_),
        .set_addr (set_addr),
        .set_     (set_),
        .flush_   (flush_),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    // Later ports are assigned last, so the highest-index writer wins.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int a = 0; a < DEPTH; a++) begin
                r_regs[a] <= '0;
            end
        end else begin
            for (int j = 0; j < WRITE; j++) begin
                if (!we_[j] && !(ZERO_REG && (waddr[j] == '0))) begin
                    r_regs[waddr[j]] <= wdata[j];
                end
            end
        end
    end

    for (genvar i = 0; i < READ; i++) begin : g_read
        logic [DATA-1:0] w_rd;
        logic            w_rb;

        always_comb begin
            w_rd = r_regs[raddr[i]];
            w_rb = w_busy[raddr[i]];
            if (BYPASS) begin
                for (int j = 0; j < WRITE; j++) begin
                    if (!we_[j] && (waddr[j] == raddr[i])) begin
                        w_rd = wdata[j];
                        w_rb = 1'b0;
                    end
                end
            end
            if (ZERO_REG && (raddr[i] == '0)) begin
                w_rd = '0;
                w_rb = 1'b0;
            end
            // Bypass is combinational, so reset must mask it explicitly.
            if (!reset_) begin
                w_rd = '0;
                w_rb = 1'b0;
            end
        end

        assign rdata[i] = w_rd;
        assign rbusy[i] = w_rb;
    end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The module SHALL have parameter DATA, default 32, register bit width.
REQ-002 The module SHALL have parameter ADDR, default 5, address width; DEPTH = 2**ADDR registers.
REQ-003 The module SHALL have parameter READ, default 4, number of read ports.
REQ-004 The module SHALL have parameter WRITE, default 2, number of write ports.
REQ-005 The module SHALL have parameter ISSUE, default 2, number of busy-set ports.
REQ-006 The module SHALL have parameter bit ZERO_REG, default 0; when 1, register 0 is hard zero.
REQ-007 The module SHALL have parameter bit BYPASS, default 1; when 1, same-cycle write-to-read forwarding is enabled.
REQ-008 The module SHALL have ports, in this order:
 clk  in  1  clock, rising edge;
 reset_  in  1  asynchronous, active-low reset;
 raddr  in  [READ][ADDR]  read addresses;
 rdata  out  [READ][DATA]  read data;
 rbusy  out  [READ]  busy flag of the addressed register;
 waddr  in  [WRITE][ADDR]  write addresses;
 we_  in  [WRITE]  write enables, active-low;
 wdata  in  [WRITE][DATA]  write data;
 set_addr  in  [ISSUE][ADDR]  destinations marked busy;
 set_  in  [ISSUE]  busy-set enables, active-low;
 flush_  in  1  clear all busy bits, active-low, synchronous;
 busy_cnt  out  ADDR+1  number of busy registers.

Function
REQ-009 Reads SHALL be combinational (zero latency): rdata[i] = regs[raddr[i]].
REQ-010 With BYPASS=1, if any write port j has we_[j]=0 and waddr[j]=raddr[i], rdata[i] SHALL equal wdata of the highest such j.
REQ-011 Writes SHALL update regs at the rising clk edge; ports with we_=1 SHALL have no effect.
REQ-012 When several enabled write ports target one address in a cycle, the highest-index port SHALL win.
REQ-013 With ZERO_REG=1, writes to address 0 SHALL be dropped, reads of address 0 SHALL return 0 (including bypass), and busy[0] SHALL never be set.
REQ-014 busy[a] SHALL be set at the edge when any set_[k]=0 with set_addr[k]=a.
REQ-015 busy[a] SHALL be cleared at the edge when an enabled write targets a and no set targets a in the same cycle.
REQ-016 A set and a write to the same address in the same cycle SHALL leave busy[a]=1 and SHALL still update the data.
REQ-017 flush_=0 SHALL clear every busy bit at the edge, overriding all sets in that cycle; register data SHALL be unaffected and writes that cycle SHALL still occur.
REQ-018 rbusy[i] SHALL equal busy[raddr[i]]; with BYPASS=1 it SHALL read 0 when an enabled write targets raddr[i] that cycle.
REQ-019 busy_cnt SHALL be registered and SHALL equal the population count of the busy vector after each edge (0..DEPTH, no wrap).

Reset
REQ-020 reset_=0 SHALL asynchronously clear all registers, all busy bits and busy_cnt to 0.
REQ-021 During reset, rdata SHALL read 0 and rbusy SHALL read 0; sets and writes SHALL be ignored.
REQ-022 Release of reset mid-operation SHALL resume normal behaviour from the first following rising edge.

Structure
REQ-023 The DATA/ADDR defaults and a shared busy-vector width constant SHALL reside in package regfile_pkg.
REQ-024 Busy tracking and busy_cnt SHALL be implemented in sub-module regfile_sb_busy; data storage and bypass SHALL remain in regfile_sb.

Verification
REQ-025 Write 0xDEAD_BEEF to r5 on port 0 while reading r5 -> rdata=0xDEAD_BEEF the same cycle (BYPASS=1) and the next cycle (BYPASS=0).
REQ-026 Ports 0 and 1 both write r7 (0x11, 0x22) -> r7=0x22 after the edge.
REQ-027 ZERO_REG=1, write 0xFF to r0 and set busy on r0 -> r0 reads 0, busy_cnt stays 0.
REQ-028 Set r3 and r4; next cycle write r3 while setting r3 again -> busy_cnt 2 then 2, r3 data updated, rbusy(r3)=1.
REQ-029 Set r1, r2 and r9, then flush_=0 while setting r10 -> all busy 0, busy_cnt=0 after the edge.
REQ-030 Assert reset_=0 mid-sequence with busy_cnt=3 -> busy_cnt, regs and rdata read 0 immediately, without waiting for a clock edge.
